// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
//   state_e          : controller FSM state encoding
//   DRAIN_CYCLES_DEF : default number of flush cycles between HLT and HALTED
//   STALL_CNT_W      : width of the stall-cycle performance counter
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      StRun    = 2'd0,
      StBrWait = 2'd1,
      StDrain  = 2'd2,
      StHalted = 2'd3
   } state_e;

   localparam int unsigned DRAIN_CYCLES_DEF = 4;
   localparam int unsigned STALL_CNT_W      = 16;

endpackage

// File: rtl/sat_ctr.sv
// Width-parameterised saturating up-counter.
//   clk, rst_n : clock, asynchronous active-low reset (clears the count)
//   inc        : add one, unless already at all-ones
//   clr        : synchronous clear, wins over inc
//   cnt        : current count
module sat_ctr #(
   parameter int unsigned Width = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clr,
   output logic [Width-1:0] cnt
);

   logic [Width-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (inc && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the 5-stage core.
// Turns hazard stall, branch/call/halt decode and memory busy into stage
// register enables, flushes and PC-source select; handles the one-cycle
// branch wait and the halt drain; counts front-end stall cycles.
//   hz_stall, branch_id, call_id, hlt_id, br_taken, mem_busy : control inputs
//   pc_en .. mem_wb_en         : stage register enables
//   if_id_flush, id_ex_flush   : load a NOP into that pipeline register
//   pc_sel_br                  : PC takes branch/call target
//   halted                     : core halted
//   stall_cycles               : saturating front-end stall counter
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   hz_stall,
   input  logic                   branch_id,
   input  logic                   call_id,
   input  logic                   hlt_id,
   input  logic                   br_taken,
   input  logic                   mem_busy,
   output logic                   pc_en,
   output logic                   if_id_en,
   output logic                   id_ex_en,
   output logic                   ex_mem_en,
   output logic                   mem_wb_en,
   output logic                   if_id_flush,
   output logic                   id_ex_flush,
   output logic                   pc_sel_br,
   output logic                   halted,
   output logic [STALL_CNT_W-1:0] stall_cycles
);

   localparam logic [2:0] DrainLoad = 3'(DRAIN_CYCLES - 1);

   state_e     state_q, state_d;
   logic [2:0] drain_q, drain_d;
   logic       stall_inc;

   always_comb begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      id_ex_en    = 1'b1;
      ex_mem_en   = 1'b1;
      mem_wb_en   = 1'b1;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      pc_sel_br   = 1'b0;
      halted      = 1'b0;
      state_d     = state_q;
      drain_d     = drain_q;

      // Memory busy freezes everything except an already-halted core.
      if (mem_busy && (state_q != StHalted)) begin
         pc_en     = 1'b0;
         if_id_en  = 1'b0;
         id_ex_en  = 1'b0;
         ex_mem_en = 1'b0;
         mem_wb_en = 1'b0;
      end else begin
         unique case (state_q)
            StRun: begin
               if (hlt_id) begin
                  pc_en       = 1'b0;
                  if_id_flush = 1'b1;
                  state_d     = StDrain;
                  drain_d     = DrainLoad;
               end else if (call_id) begin
                  pc_sel_br   = 1'b1;
                  if_id_flush = 1'b1;
               end else if (branch_id || hz_stall) begin
                  // Branch holds in ID until flags from EX are written.
                  pc_en       = 1'b0;
                  if_id_en    = 1'b0;
                  id_ex_flush = 1'b1;
                  if (branch_id) begin
                     state_d = StBrWait;
                  end
               end
            end
            StBrWait: begin
               if (br_taken) begin
                  pc_sel_br   = 1'b1;
                  if_id_flush = 1'b1;
               end
               state_d = StRun;
            end
            StDrain: begin
               pc_en       = 1'b0;
               if_id_en    = 1'b0;
               id_ex_flush = 1'b1;
               if (drain_q == 3'd0) begin
                  state_d = StHalted;
               end else begin
                  drain_d = drain_q - 3'd1;
               end
            end
            StHalted: begin
               pc_en     = 1'b0;
               if_id_en  = 1'b0;
               id_ex_en  = 1'b0;
               ex_mem_en = 1'b0;
               mem_wb_en = 1'b0;
               halted    = 1'b1;
            end
            default: ;
         endcase
      end

      stall_inc = ((state_q == StRun) || (state_q == StBrWait)) && !mem_busy && !pc_en;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
         drain_q <= 3'd0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   sat_ctr #(
      .Width (STALL_CNT_W)
   ) u_stall_ctr (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .clr   (1'b0),
      .cnt   (stall_cycles)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized
// stimulus against a behavioural model of the controller.
module tb_pipe_ctrl;

   localparam int unsigned DC = 4;

   localparam int MRun   = 0;
   localparam int MWait  = 1;
   localparam int MDrain = 2;
   localparam int MHalt  = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        hz_stall = 1'b0, branch_id = 1'b0, call_id = 1'b0, hlt_id = 1'b0;
   logic        br_taken = 1'b0, mem_busy = 1'b0;
   logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic        if_id_flush, id_ex_flush, pc_sel_br, halted;
   logic [15:0] stall_cycles;
   logic [8:0]  obs_vec;
   logic        obs_halted;

   int n_checks = 0;
   int n_fail = 0;

   // Behavioural model: mode, non-frozen cycles left before halt, stall count.
   int m_mode = MRun;
   int m_left = 0;
   int m_stalls = 0;

   pipe_ctrl #(
      .DRAIN_CYCLES (DC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .hz_stall     (hz_stall),
      .branch_id    (branch_id),
      .call_id      (call_id),
      .hlt_id       (hlt_id),
      .br_taken     (br_taken),
      .mem_busy     (mem_busy),
      .pc_en        (pc_en),
      .if_id_en     (if_id_en),
      .id_ex_en     (id_ex_en),
      .ex_mem_en    (ex_mem_en),
      .mem_wb_en    (mem_wb_en),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .pc_sel_br    (pc_sel_br),
      .halted       (halted),
      .stall_cycles (stall_cycles)
   );

   always #5 clk = ~clk;

   assign obs_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                     if_id_flush, id_ex_flush, pc_sel_br, halted};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Expected {en[4:0], if_id_flush, id_ex_flush, pc_sel_br, halted}.
   function automatic logic [8:0] model_outs();
      logic [4:0] en;
      logic       ifl, idl, sel, hlt;
      en = 5'b11111; ifl = 0; idl = 0; sel = 0; hlt = 0;
      if (m_mode == MHalt) begin
         en = 5'b00000; hlt = 1;
      end else if (mem_busy) begin
         en = 5'b00000;
      end else if (m_mode == MRun) begin
         if (hlt_id) begin
            en[4] = 0; ifl = 1;
         end else if (call_id) begin
            sel = 1; ifl = 1;
         end else if (branch_id || hz_stall) begin
            en[4] = 0; en[3] = 0; idl = 1;
         end
      end else if (m_mode == MWait) begin
         if (br_taken) begin
            sel = 1; ifl = 1;
         end
      end else begin
         en[4] = 0; en[3] = 0; idl = 1;
      end
      return {en, ifl, idl, sel, hlt};
   endfunction

   task automatic model_advance(input logic [8:0] e);
      if (m_mode == MHalt || mem_busy) return;
      if ((m_mode == MRun || m_mode == MWait) && !e[8] && m_stalls < 65535) m_stalls++;
      case (m_mode)
         MRun: begin
            if (hlt_id) begin
               m_mode = MDrain;
               m_left = DC;
            end else if (!call_id && branch_id) begin
               m_mode = MWait;
            end
         end
         MWait: m_mode = MRun;
         MDrain: begin
            m_left--;
            if (m_left == 0) m_mode = MHalt;
         end
         default: ;
      endcase
   endtask

   task automatic step(input logic hz, input logic br, input logic ca, input logic hl,
                       input logic tk, input logic mb);
      logic [8:0] e;
      @(negedge clk);
      hz_stall = hz; branch_id = br; call_id = ca; hlt_id = hl; br_taken = tk; mem_busy = mb;
      #1;
      e = model_outs();
      check("outputs", 32'(obs_vec), 32'(e));
      check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
      obs_halted = halted;
      @(posedge clk);
      model_advance(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      hz_stall = 0; branch_id = 0; call_id = 0; hlt_id = 0; br_taken = 0; mem_busy = 0;
      #2 rst_n = 1'b0;
      #1;
      m_mode = MRun; m_left = 0; m_stalls = 0;
      check("reset_outputs", 32'(obs_vec), 32'(9'b111110000));
      check("reset_stall", 32'(stall_cycles), 32'd0);
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int lat;
      do_reset();

      // Idle.
      repeat (3) step(0, 0, 0, 0, 0, 0);

      // Hazard stall for three cycles.
      repeat (3) step(1, 0, 0, 0, 0, 0);
      #1 check("hz_stall_count", 32'(stall_cycles), 32'd3);

      // Branch taken, then not taken; each costs one stall cycle.
      do_reset();
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      check("br_taken_outs", 32'(obs_vec), 32'(9'b111111010));
      step(0, 0, 0, 0, 0, 0);
      check("br_back_run", 32'(obs_vec), 32'(9'b111110000));
      check("br_stall_count", 32'(stall_cycles), 32'd1);
      step(1, 1, 0, 0, 0, 0);
      step(1, 1, 1, 1, 0, 0);
      check("br_not_taken_outs", 32'(obs_vec), 32'(9'b111110000));
      #1 check("br_nt_stall_count", 32'(stall_cycles), 32'd2);

      // Branch with memory busy during the wait.
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      check("busy_freeze", 32'(obs_vec), 32'd0);
      step(0, 0, 0, 0, 1, 0);
      check("busy_then_taken", 32'(obs_vec), 32'(9'b111111010));

      // Halt latency.
      do_reset();
      step(0, 0, 0, 1, 0, 0);
      lat = 0;
      obs_halted = 1'b0;
      while (!obs_halted && lat < 20) begin
         step(0, 0, 0, 0, 0, 0);
         lat++;
      end
      check("halt_latency", 32'(lat), 32'(DC + 1));
      step(0, 1, 0, 1, 1, 1);
      step(1, 0, 1, 1, 0, 0);
      check("halted_ignores", 32'(obs_vec), 32'(9'b000000001));
      do_reset();
      step(0, 0, 0, 0, 0, 0);

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 99) < 2) begin
            do_reset();
         end else begin
            step(($urandom % 4) == 0, ($urandom % 6) == 0, ($urandom % 10) == 0,
                 ($urandom % 40) == 0, ($urandom % 2) == 0, ($urandom % 5) == 0);
         end
      end

      // Counter saturation.
      do_reset();
      repeat (65537) step(1, 0, 0, 0, 0, 0);
      #1 check("stall_saturate", 32'(stall_cycles), 32'h0000ffff);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
